// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port synchronous data memory.
// One transaction at a time: IDLE -> ISSUE -> (RDWAIT) -> RESP -> IDLE, all outputs registered.
module mem_arbiter #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 16,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } cmd_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;

  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          busy_q, busy_d;
  cmd_e          mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          win;

  // Winning port index; only meaningful when at least one request is present.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      win = ~req0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_cmd_q    <= MNONE;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      write_data_q <= write_data_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d      = S_ISSUE;
          owner_d      = win;
          last_grant_d = win;
          lat_we_d     = win ? we1 : we0;
          lat_addr_d   = win ? addr1 : addr0;
          lat_wdata_d  = win ? wdata1 : wdata0;
        end
      end
      S_ISSUE:  state_d = lat_we_q ? S_RESP : S_RDWAIT;
      S_RDWAIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered bus shows
  // ISSUE values in the very cycle the FSM is in ISSUE.
  always_comb begin
    gnt0_d       = (state_d != S_IDLE) && !owner_d;
    gnt1_d       = (state_d != S_IDLE) && owner_d;
    done0_d      = (state_d == S_RESP) && !owner_d;
    done1_d      = (state_d == S_RESP) && owner_d;
    busy_d       = (state_d != S_IDLE);
    mem_cmd_d    = MNONE;
    mem_addr_d   = mem_addr_q;
    write_data_d = write_data_q;
    rdata_d      = rdata_q;
    case (state_d)
      S_ISSUE: begin
        mem_addr_d = lat_addr_d;
        if (lat_we_d) begin
          mem_cmd_d    = MWRITE;
          write_data_d = lat_wdata_d;
        end else begin
          mem_cmd_d = MREAD;
        end
      end
      S_RDWAIT: mem_cmd_d = MREAD;
      default:  mem_cmd_d = MNONE;
    endcase
    if (state_q == S_RDWAIT) begin
      rdata_d = read_data;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign busy       = busy_q;
  assign mem_cmd    = mem_cmd_q;
  assign mem_addr   = mem_addr_q;
  assign write_data = write_data_q;
  assign rdata      = rdata_q;

  a_gnt_excl: assert property (@(posedge clk) disable iff (reset) !(gnt0_q && gnt1_q));
  a_done_excl: assert property (@(posedge clk) disable iff (reset) !(done0_q && done1_q));
  a_single_write: assert property (@(posedge clk) disable iff (reset)
    (mem_cmd_q == MWRITE) |=> (mem_cmd_q != MWRITE));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory (mem_cmd/mem_addr/read_data/write_data bus) between two requesters.
  - Port 0: the CPU, for instruction fetch and LDR/STR.
  - Port 1: the loader/debug port, which fills memory and peeks at it.
- Runs one memory transaction at a time through a small FSM.
- Owns the memory command bus outright; the CPU no longer drives mem_cmd directly.

Parameters:
- AW, 9: memory address width.
- DW, 16: data width.
- FIXED_PRIO, 0:
  - 0 = round-robin on simultaneous requests.
  - 1 = port 0 always wins.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held until done0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- req1, we1, addr1, wdata1  in  1/1/AW/DW  same roles for port 1.
- gnt0  out  1  port 0 owns the bus (ISSUE through RESP).
- gnt1  out  1  port 1 owns the bus.
- done0  out  1  one-cycle pulse: port 0 transaction complete.
- done1  out  1  one-cycle pulse: port 1 transaction complete.
- rdata  out  DW  registered read result; valid while doneX=1.
- busy  out  1  FSM not in IDLE.
- mem_cmd  out  2  memory command: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
- mem_addr  out  AW  memory address.
- write_data  out  DW  memory write data.
- read_data  in  DW  memory read data; valid the cycle after MREAD is first presented (synchronous RAM).

Behaviour:
- Reset (synchronous; takes effect at the clock edge where reset=1):
  - state=IDLE, mem_cmd=MNONE, mem_addr=0, write_data=0, rdata=0.
  - gnt0=gnt1=done0=done1=0, busy=0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset in any state aborts the transaction: no done pulse, MNONE from the next cycle.
- All outputs are registered. The winner's we/addr/wdata are latched in IDLE on the grant edge.
- States:
  - IDLE: mem_cmd=MNONE, no gnt.
    - No req -> stay.
    - Any req -> choose winner, latch its fields, go ISSUE.
  - ISSUE: gntX=1, mem_addr=latched addr.
    - Write: mem_cmd=MWRITE, write_data=latched wdata, -> RESP.
    - Read: mem_cmd=MREAD, -> RDWAIT.
  - RDWAIT: mem_cmd=MREAD, address held. Capture read_data into rdata at the end of the cycle, -> RESP.
  - RESP: mem_cmd=MNONE, gntX=1, doneX=1 for exactly one cycle, -> IDLE.
- Latency, counted from the edge where req is sampled high in IDLE:
  - Write: 2 cycles to done.
  - Read: 3 cycles to done.
  - Minimum back-to-back spacing is one IDLE cycle between transactions.
- Arbitration (evaluated only in IDLE):
  - Single requester: it wins.
  - Both, FIXED_PRIO=0: the port != last_grant wins.
  - Both, FIXED_PRIO=1: port 0 wins.
  - last_grant updates on every grant.
- Handshake rules:
  - The requester must hold req/we/addr/wdata stable until doneX. Changes after the grant edge are ignored because fields are latched.
  - If req drops mid-transaction, the transaction still completes and doneX still pulses.
  - A requester must drop req in its RESP cycle. If req is still high in the following IDLE, it counts as a new request.
- rdata:
  - Holds its last read value until the next read capture.
  - A write does not alter rdata.
- mem_addr and write_data hold their last values in IDLE/RESP; only mem_cmd returns to MNONE.
- Invariants:
  - gnt0 and gnt1 are never both high.
  - done0 and done1 are never both high.
  - mem_cmd is never MWRITE for more than one consecutive cycle per transaction.

Test Plan:
- Reset, then port 0 write with addr0=9'h005, wdata0=16'hABCD -> mem_cmd=MWRITE, mem_addr=5, write_data=ABCD in the cycle after the request; done0 one cycle later; gnt1 stays 0.
- Port 1 read of addr 9'h005 from a RAM model preloaded with ABCD -> MREAD for 2 cycles; done1 on the 3rd cycle after the request with rdata=16'hABCD; rdata unchanged afterwards.
- req0 and req1 both rise together after reset, FIXED_PRIO=0, both held continuously -> grant order 0,1,0,1; each done pulse lands on the correct port.
- Same stimulus with FIXED_PRIO=1 -> port 0 is served every transaction while it keeps requesting; port 1 is served only when req0=0 in IDLE.
- Reset asserted during RDWAIT of a port 0 read -> next cycle state=IDLE, mem_cmd=MNONE, no done0, rdata=0, busy=0.
- Port 0 drops req0 during ISSUE of a write -> the write still occurs and done0 pulses. Port 0 holds req0 through RESP -> a second identical write is issued after one IDLE cycle.
